// File: rtl/sequencer_pkg.sv
// Shared definitions for the micro-sequencer: opcodes, control-word bit indices and state encoding.
package sequencer_pkg;

  localparam int CTRL_W = 16;

  localparam int B_HLT = 15;
  localparam int B_CP  = 14;
  localparam int B_EP  = 13;
  localparam int B_MI  = 12;
  localparam int B_RO  = 11;
  localparam int B_RI  = 10;
  localparam int B_II  = 9;
  localparam int B_IO  = 8;
  localparam int B_AI  = 7;
  localparam int B_AO  = 6;
  localparam int B_SU  = 5;
  localparam int B_EU  = 4;
  localparam int B_BI  = 3;
  localparam int B_OI  = 2;
  localparam int B_J   = 1;
  localparam int B_FI  = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // T-states carry their own step number so T_State can be loaded straight from the state.
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_T3   = 4'd3,
    ST_T4   = 4'd4,
    ST_T5   = 4'd5,
    ST_T6   = 4'd6,
    ST_T7   = 4'd7,
    ST_T8   = 4'd8,
    ST_HALT = 4'd15
  } state_t;

  function automatic logic [CTRL_W-1:0] cbit(input int idx);
    return {{(CTRL_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: control word, end-of-instruction and illegal-opcode flags for one T-step.
module microcode_rom
  import sequencer_pkg::*;
#(
  parameter int TMAX      = 5,
  parameter int FIXED_LEN = 0,
  parameter int OPW       = 4
) (
  input  logic [OPW-1:0]    opcode,
  input  logic [3:0]        step,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [CTRL_W-1:0] ctrl,
  output logic              last,
  output logic              illegal
);

  localparam logic [3:0] T_LAST = 4'(TMAX);

  logic [CTRL_W-1:0] w3, w4, w5;
  logic [3:0]        len;

  always_comb begin
    w3      = '0;
    w4      = '0;
    w5      = '0;
    len     = 4'd3;
    illegal = 1'b0;
    if ((opcode >> 4) != '0) begin
      illegal = 1'b1;
    end else begin
      case (opcode[3:0])
        OP_NOP: ;
        OP_LDA: begin
          w3  = cbit(B_IO) | cbit(B_MI);
          w4  = cbit(B_RO) | cbit(B_AI);
          len = 4'd4;
        end
        OP_ADD, OP_SUB: begin
          w3  = cbit(B_IO) | cbit(B_MI);
          w4  = cbit(B_RO) | cbit(B_BI);
          w5  = cbit(B_EU) | cbit(B_AI) | cbit(B_FI);
          if (opcode[3:0] == OP_SUB) w5 = w5 | cbit(B_SU);
          len = 4'd5;
        end
        OP_STA: begin
          w3  = cbit(B_IO) | cbit(B_MI);
          w4  = cbit(B_AO) | cbit(B_RI);
          len = 4'd4;
        end
        OP_LDI: w3 = cbit(B_IO) | cbit(B_AI);
        OP_JMP: w3 = cbit(B_IO) | cbit(B_J);
        OP_JC:  if (flag_c) w3 = cbit(B_IO) | cbit(B_J);
        OP_JZ:  if (flag_z) w3 = cbit(B_IO) | cbit(B_J);
        OP_OUT: w3 = cbit(B_AO) | cbit(B_OI);
        OP_HLT: w3 = cbit(B_HLT);
        default: illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    case (step)
      4'd1:    ctrl = cbit(B_EP) | cbit(B_MI);
      4'd2:    ctrl = cbit(B_RO) | cbit(B_II) | cbit(B_CP);
      4'd3:    ctrl = w3;
      4'd4:    ctrl = w4;
      4'd5:    ctrl = w5;
      default: ctrl = '0;
    endcase
    // Steps beyond TMAX are truncated: TMAX always ends the instruction.
    if (FIXED_LEN != 0) last = (step >= T_LAST);
    else                last = (step >= len) || (step >= T_LAST);
  end

endmodule

// File: rtl/micro_sequencer.sv
// T-state sequencer: state register, step gating, registered control outputs and sticky error flag.
module micro_sequencer
  import sequencer_pkg::*;
#(
  parameter int TMAX      = 5,
  parameter int FIXED_LEN = 0,
  parameter int OPW       = 4
) (
  input  logic              Clock,
  input  logic              Clear_n,
  input  logic [OPW-1:0]    opcode,
  input  logic              flag_c,
  input  logic              flag_z,
  input  logic              step_mode,
  input  logic              step,
  input  logic              resume,
  output logic [CTRL_W-1:0] ctrl,
  output logic [3:0]        T_State,
  output logic              error_LED
);

  logic [1:0]        rst_sync;
  logic              rst_int_n;
  state_t            state, state_nxt;
  logic              load, advance, last_q;
  logic [OPW-1:0]    op_q, rom_op;
  logic [3:0]        rom_step;
  logic [CTRL_W-1:0] rom_ctrl;
  logic              rom_last, rom_illegal;

  // Assertion is immediate; release reaches the sequencer two edges later.
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign advance = !step_mode || step;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (advance) begin
          state_nxt = ST_T1;
          load      = 1'b1;
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_nxt = ST_T1;
          load      = 1'b1;
        end
      end
      default: begin
        if (advance) begin
          load = 1'b1;
          if (ctrl[B_HLT])  state_nxt = ST_HALT;
          else if (last_q)  state_nxt = ST_T1;
          else              state_nxt = state_t'(state + 4'd1);
        end
      end
    endcase
  end

  assign rom_step = state_nxt;
  assign rom_op   = (state_nxt == ST_T3) ? opcode : op_q;

  microcode_rom #(
    .TMAX      (TMAX),
    .FIXED_LEN (FIXED_LEN),
    .OPW       (OPW)
  ) u_rom (
    .opcode  (rom_op),
    .step    (rom_step),
    .flag_c  (flag_c),
    .flag_z  (flag_z),
    .ctrl    (rom_ctrl),
    .last    (rom_last),
    .illegal (rom_illegal)
  );

  always_ff @(posedge Clock or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state     <= ST_IDLE;
      ctrl      <= '0;
      T_State   <= '0;
      last_q    <= 1'b0;
      op_q      <= '0;
      error_LED <= 1'b0;
    end else if (load) begin
      state  <= state_nxt;
      last_q <= rom_last;
      if (state_nxt == ST_HALT) begin
        ctrl    <= cbit(B_HLT);
        T_State <= '0;
      end else begin
        ctrl    <= rom_ctrl;
        T_State <= rom_step;
      end
      if (state_nxt == ST_T3) begin
        op_q <= opcode;
        if (rom_illegal) error_LED <= 1'b1;
      end
      if (state == ST_HALT) error_LED <= 1'b0;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: three configurations checked against an instruction-level trace model.
module tb_micro_sequencer;

  typedef logic [15:0] wq_t[$];
  typedef logic [4:0]  opq_t[$];

  localparam logic [15:0] HLT = 16'h8000, CP = 16'h4000, EP = 16'h2000, MI = 16'h1000;
  localparam logic [15:0] RO  = 16'h0800, RI = 16'h0400, II = 16'h0200, IO = 16'h0100;
  localparam logic [15:0] AI  = 16'h0080, AO = 16'h0040, SU = 16'h0020, EU = 16'h0010;
  localparam logic [15:0] BI  = 16'h0008, OI = 16'h0004, J  = 16'h0002, FI = 16'h0001;
  localparam logic [15:0] FETCH1 = EP | MI;
  localparam logic [15:0] FETCH2 = RO | II | CP;

  logic        Clock = 1'b0;
  logic        Clear_n;
  logic [3:0]  op0, op2;
  logic [4:0]  op1;
  logic        fc0, fz0, fc1, fz1, fc2, fz2;
  logic        step_mode, step, resume;
  logic [15:0] ctrl0, ctrl1, ctrl2;
  logic [3:0]  t0, t1, t2;
  logic        e0, e1, e2;
  int          total = 0;
  int          bad = 0;

  always #5 Clock = ~Clock;

  // lane 0: defaults; lane 1: FIXED_LEN=1, 5-bit opcode; lane 2: TMAX=3 truncation
  micro_sequencer dut (
    .Clock(Clock), .Clear_n(Clear_n), .opcode(op0), .flag_c(fc0), .flag_z(fz0),
    .step_mode(step_mode), .step(step), .resume(resume),
    .ctrl(ctrl0), .T_State(t0), .error_LED(e0));

  micro_sequencer #(.TMAX(5), .FIXED_LEN(1), .OPW(5)) dut_fx (
    .Clock(Clock), .Clear_n(Clear_n), .opcode(op1), .flag_c(fc1), .flag_z(fz1),
    .step_mode(step_mode), .step(step), .resume(resume),
    .ctrl(ctrl1), .T_State(t1), .error_LED(e1));

  micro_sequencer #(.TMAX(3), .FIXED_LEN(0), .OPW(4)) dut_tr (
    .Clock(Clock), .Clear_n(Clear_n), .opcode(op2), .flag_c(fc2), .flag_z(fz2),
    .step_mode(step_mode), .step(step), .resume(resume),
    .ctrl(ctrl2), .T_State(t2), .error_LED(e2));

  function automatic logic [3:0] lane_t(int ln);
    case (ln)
      0:       return t0;
      1:       return t1;
      default: return t2;
    endcase
  endfunction

  function automatic logic [15:0] lane_c(int ln);
    case (ln)
      0:       return ctrl0;
      1:       return ctrl1;
      default: return ctrl2;
    endcase
  endfunction

  function automatic logic lane_e(int ln);
    case (ln)
      0:       return e0;
      1:       return e1;
      default: return e2;
    endcase
  endfunction

  task automatic drive(int ln, logic [4:0] op, logic fc, logic fz);
    case (ln)
      0:       begin op0 = op[3:0]; fc0 = fc; fz0 = fz; end
      1:       begin op1 = op;      fc1 = fc; fz1 = fz; end
      default: begin op2 = op[3:0]; fc2 = fc; fz2 = fz; end
    endcase
  endtask

  function automatic bit is_illegal(logic [4:0] op);
    return op[4] || (op[3:0] inside {[4'd9:4'd13]});
  endfunction

  // Execute-phase control words (T3 onward) straight from the instruction table.
  function automatic wq_t op_body(logic [4:0] op, logic fc, logic fz);
    wq_t b;
    if (is_illegal(op)) b.push_back(16'h0);
    else begin
      case (op[3:0])
        4'h1: begin b.push_back(IO | MI); b.push_back(RO | AI); end
        4'h2: begin b.push_back(IO | MI); b.push_back(RO | BI); b.push_back(EU | AI | FI); end
        4'h3: begin b.push_back(IO | MI); b.push_back(RO | BI); b.push_back(SU | EU | AI | FI); end
        4'h4: begin b.push_back(IO | MI); b.push_back(AO | RI); end
        4'h5: b.push_back(IO | AI);
        4'h6: b.push_back(IO | J);
        4'h7: b.push_back(fc ? (IO | J) : 16'h0);
        4'h8: b.push_back(fz ? (IO | J) : 16'h0);
        4'hE: b.push_back(AO | OI);
        4'hF: b.push_back(HLT);
        default: b.push_back(16'h0);
      endcase
    end
    return b;
  endfunction

  // Called at the falling edge where the lane has just entered T1.
  task automatic exec_lane(int ln, logic [4:0] op, logic fc, logic fz, int tmax, bit fixed,
                           inout bit err_exp);
    wq_t         b;
    int          n;
    logic [15:0] w;
    b = op_body(op, fc, fz);
    n = 2 + b.size();
    if (fixed) n = tmax;
    if (n > tmax) n = tmax;
    if (op == 5'h0F) n = 3;
    drive(ln, op, fc, fz);
    for (int s = 1; s <= n; s++) begin
      if (s == 1)               w = FETCH1;
      else if (s == 2)          w = FETCH2;
      else if (s - 3 < b.size()) w = b[s-3];
      else                      w = 16'h0;
      if (s == 3 && is_illegal(op)) err_exp = 1'b1;
      total++;
      if (lane_t(ln) !== 4'(s) || lane_c(ln) !== w || lane_e(ln) !== err_exp) begin
        bad++;
        $display("FAIL lane%0d op=%h T%0d: got T_State=%0d ctrl=%h error_LED=%b, want T_State=%0d ctrl=%h error_LED=%b",
                 ln, op, s, lane_t(ln), lane_c(ln), lane_e(ln), s, w, err_exp);
      end
      if (s == 3) drive(ln, op, 1'($urandom), 1'($urandom));
      @(negedge Clock);
    end
  endtask

  task automatic check_lane(string name, int ln, logic [3:0] t, logic [15:0] c, logic e);
    total++;
    if (lane_t(ln) !== t || lane_c(ln) !== c || lane_e(ln) !== e) begin
      bad++;
      $display("FAIL %s lane%0d: got T_State=%0d ctrl=%h error_LED=%b, want T_State=%0d ctrl=%h error_LED=%b",
               name, ln, lane_t(ln), lane_c(ln), lane_e(ln), t, c, e);
    end
  endtask

  task automatic check_zero(string name);
    for (int ln = 0; ln < 3; ln++) check_lane(name, ln, 4'd0, 16'h0, 1'b0);
  endtask

  task automatic release_reset();
    int waited;
    Clear_n = 1'b1;
    @(negedge Clock);
    check_zero("release_sync");
    waited = 1;
    while (t0 !== 4'd1 && waited < 5) begin
      @(negedge Clock);
      waited++;
    end
    for (int ln = 0; ln < 3; ln++) check_lane("release_t1", ln, 4'd1, FETCH1, 1'b0);
  endtask

  task automatic do_reset();
    for (int ln = 0; ln < 3; ln++) drive(ln, 5'h00, 1'b0, 1'b0);
    step_mode = 1'b0;
    step      = 1'b0;
    resume    = 1'b0;
    #2 Clear_n = 1'b0;
    #1 check_zero("async_clear");
    @(negedge Clock);
    check_zero("reset_hold");
    release_reset();
  endtask

  task automatic resume_from_halt(logic e_before);
    check_lane("halt_before_resume", 0, 4'd0, HLT, e_before);
    resume = 1'b1;
    @(negedge Clock);
    resume = 1'b0;
    check_lane("resume_to_t1", 0, 4'd1, FETCH1, 1'b0);
  endtask

  task automatic run_list(int ln, int tmax, bit fixed, opq_t ops);
    bit err;
    err = 1'b0;
    foreach (ops[i]) exec_lane(ln, ops[i], 1'($urandom), 1'($urandom), tmax, fixed, err);
  endtask

  task automatic test_reset();
    Clear_n = 1'b0;
    step_mode = 1'b0; step = 1'b0; resume = 1'b0;
    for (int ln = 0; ln < 3; ln++) drive(ln, 5'h00, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge Clock);
      check_zero("power_on_reset");
    end
    release_reset();
  endtask

  task automatic test_lda_hlt();
    bit err;
    do_reset();
    err = 1'b0;
    exec_lane(0, 5'h01, 1'b0, 1'b0, 5, 1'b0, err);
    exec_lane(0, 5'h0F, 1'b0, 1'b0, 5, 1'b0, err);
    for (int i = 0; i < 10; i++) begin
      check_lane("halt_hold", 0, 4'd0, HLT, 1'b0);
      @(negedge Clock);
    end
    resume_from_halt(1'b0);
  endtask

  task automatic test_cond_jumps();
    bit err;
    do_reset();
    err = 1'b0;
    exec_lane(0, 5'h08, 1'b0, 1'b1, 5, 1'b0, err);
    exec_lane(0, 5'h08, 1'b1, 1'b0, 5, 1'b0, err);
    check_lane("jz_not_taken_back_to_t1", 0, 4'd1, FETCH1, 1'b0);
    exec_lane(0, 5'h07, 1'b1, 1'b0, 5, 1'b0, err);
    exec_lane(0, 5'h07, 1'b0, 1'b1, 5, 1'b0, err);
    check_lane("jc_back_to_t1", 0, 4'd1, FETCH1, 1'b0);
  endtask

  task automatic test_fixed_len();
    bit err;
    do_reset();
    err = 1'b0;
    exec_lane(1, 5'h05, 1'b0, 1'b0, 5, 1'b1, err);
    check_lane("fixed_ldi_back_to_t1", 1, 4'd1, FETCH1, 1'b0);
    exec_lane(1, 5'h15, 1'b0, 1'b0, 5, 1'b1, err);
    exec_lane(1, 5'h03, 1'b0, 1'b0, 5, 1'b1, err);
    check_lane("fixed_err_sticky", 1, 4'd1, FETCH1, 1'b1);
  endtask

  task automatic test_truncation();
    bit err;
    do_reset();
    err = 1'b0;
    exec_lane(2, 5'h02, 1'b0, 1'b0, 3, 1'b0, err);
    exec_lane(2, 5'h01, 1'b0, 1'b0, 3, 1'b0, err);
    check_lane("trunc_back_to_t1", 2, 4'd1, FETCH1, 1'b0);
  endtask

  task automatic step_expect(string name, logic [3:0] t, logic [15:0] w, logic with_resume);
    step   = 1'b1;
    resume = with_resume;
    @(negedge Clock);
    step   = 1'b0;
    resume = 1'b0;
    check_lane(name, 0, t, w, 1'b0);
    repeat (3) begin
      @(negedge Clock);
      check_lane({name, "_stable"}, 0, t, w, 1'b0);
    end
  endtask

  task automatic test_single_step();
    wq_t b;
    do_reset();
    step_mode = 1'b1;
    drive(0, 5'h02, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge Clock);
      check_lane("step_idle_hold", 0, 4'd1, FETCH1, 1'b0);
    end
    b = op_body(5'h02, 1'b0, 1'b0);
    step_expect("step_t2", 4'd2, FETCH2, 1'b1);
    for (int k = 0; k < b.size(); k++) step_expect("step_add", 4'(3 + k), b[k], 1'b0);
    step_expect("step_wrap", 4'd1, FETCH1, 1'b0);
    drive(0, 5'h0F, 1'b0, 1'b0);
    step_expect("step_hlt_t2", 4'd2, FETCH2, 1'b0);
    step_expect("step_hlt_t3", 4'd3, HLT, 1'b0);
    step_expect("step_enter_halt", 4'd0, HLT, 1'b0);
    step_expect("step_in_halt", 4'd0, HLT, 1'b0);
    resume_from_halt(1'b0);
    step_mode = 1'b0;
  endtask

  task automatic test_illegal_resume();
    bit err;
    do_reset();
    err = 1'b0;
    exec_lane(0, 5'h0A, 1'b0, 1'b0, 5, 1'b0, err);
    exec_lane(0, 5'h0F, 1'b0, 1'b0, 5, 1'b0, err);
    repeat (3) begin
      check_lane("illegal_halt_hold", 0, 4'd0, HLT, 1'b1);
      @(negedge Clock);
    end
    resume_from_halt(1'b1);
  endtask

  task automatic test_reset_mid();
    bit err;
    do_reset();
    drive(0, 5'h02, 1'b0, 1'b0);
    repeat (3) @(negedge Clock);
    check_lane("add_t4_before_clear", 0, 4'd4, RO | BI, 1'b0);
    #2 Clear_n = 1'b0;
    #1 check_lane("mid_clear_async", 0, 4'd0, 16'h0, 1'b0);
    @(negedge Clock);
    check_lane("mid_clear_hold", 0, 4'd0, 16'h0, 1'b0);
    release_reset();
    err = 1'b0;
    exec_lane(0, 5'h02, 1'b0, 1'b0, 5, 1'b0, err);
    check_lane("refetch_done", 0, 4'd1, FETCH1, 1'b0);
  endtask

  task automatic test_random();
    opq_t        q0, q1, q2;
    logic [4:0]  v;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      q0.push_back(5'($urandom_range(0, 14)));
      q2.push_back(5'($urandom_range(0, 14)));
      v = 5'($urandom_range(0, 14));
      if ($urandom_range(0, 7) == 0) v[4] = 1'b1;
      q1.push_back(v);
    end
    fork
      run_list(0, 5, 1'b0, q0);
      run_list(1, 5, 1'b1, q1);
      run_list(2, 3, 1'b0, q2);
    join
  endtask

  initial begin
    test_reset();
    test_lda_hlt();
    test_cond_jumps();
    test_fixed_len();
    test_truncation();
    test_single_step();
    test_illegal_resume();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter TMAX, default 5: maximum T-states per instruction, legal range 3..8.
REQ-002 Parameter FIXED_LEN, default 0: 1 pads every instruction to TMAX states, with zero control words in the padded states.
REQ-003 Parameter OPW, default 4: opcode width; opcode bits above [3:0] must be zero, otherwise the opcode is illegal.
REQ-004 Clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 Clear_n  in  1  reset, asynchronous, active-low.
REQ-006 opcode  in  OPW  instruction register contents, valid from the rising edge that ends T2.
REQ-007 flag_c, flag_z  in  1 each  carry and zero flags, sampled in T3.
REQ-008 step_mode  in  1  1 = single-step; state advances only on cycles with step=1.
REQ-009 step  in  1  single-step advance strobe, one cycle wide.
REQ-010 resume  in  1  leave HALT.
REQ-011 ctrl  out  16  registered control word; bit order {HLT,CP,EP,MI,RO,RI,II,IO,AI,AO,SU,EU,BI,OI,J,FI}, MSB first.
REQ-012 T_State  out  4  current step: 1..TMAX; 0 in IDLE and HALT.
REQ-013 error_LED  out  1  sticky illegal-opcode flag.

Function
REQ-014 The state machine SHALL have the states IDLE, T1..TMAX and HALT.
REQ-015 Transitions:
- IDLE->T1 unconditionally.
- Tn->Tn+1 unless Tn is the last step.
- last step->T1.
- HLT step->HALT.
- HALT->T1 when resume=1.
REQ-016 Advance SHALL occur on every cycle when step_mode=0, and only on cycles with step=1 when step_mode=1; otherwise state, ctrl and T_State hold.
REQ-017 ctrl and T_State SHALL be registered, loaded with the values for the state being entered on the same edge, so they are valid for the whole state.
REQ-018 Fetch: T1 = EP|MI; T2 = RO|II|CP.
REQ-019 Per-opcode steps:
- NOP 0000: T3 = 0.
- LDA 0001: T3 = IO|MI, T4 = RO|AI.
- ADD 0010: T3 = IO|MI, T4 = RO|BI, T5 = EU|AI|FI.
- SUB 0011: as ADD, with T5 = SU|EU|AI|FI.
- STA 0100: T3 = IO|MI, T4 = AO|RI.
- LDI 0101: T3 = IO|AI.
- JMP 0110: T3 = IO|J.
- JC 0111: T3 = IO|J if flag_c=1, else 0.
- JZ 1000: T3 = IO|J if flag_z=1, else 0.
- OUT 1110: T3 = AO|OI.
- HLT 1111: T3 = HLT.
REQ-020 When FIXED_LEN=0, the last listed step of each opcode SHALL be the last step; when FIXED_LEN=1, TMAX is always the last step.
REQ-021 Any steps that would exceed TMAX SHALL be truncated, and the instruction ends at TMAX.
REQ-022 Illegal opcode in T3 SHALL set error_LED and execute as NOP; error_LED clears only on reset or on resume while in HALT.
REQ-023 In HALT, ctrl SHALL be HLT-only and T_State 0; resume and step_mode=1 with no step SHALL still exit HALT on resume (resume overrides stepping).
REQ-024 flag_c and flag_z SHALL be sampled only when entering T3; later flag changes do not affect the instruction.
REQ-025 If resume and an advance coincide outside HALT, resume SHALL be ignored.

Reset
REQ-026 Clear_n=0 SHALL immediately force state IDLE, ctrl=16'h0000, T_State=0, error_LED=0, regardless of Clock.
REQ-027 Reset deasserted mid-instruction SHALL restart at IDLE then T1, with no partial instruction resumed.
REQ-028 Reset deassertion SHALL be synchronised internally by a two-flop release so that the first T1 follows cleanly.

Structure
REQ-029 Package sequencer_pkg SHALL hold the opcode constants, the ctrl bit-index constants and the state enum.
REQ-030 Sub-module microcode_rom SHALL be combinational: inputs (opcode, step, flag_c, flag_z, FIXED_LEN, TMAX); outputs ctrl word, last, illegal.
REQ-031 micro_sequencer SHALL hold the state register, advance gating, output registers and error latch.

Verification
REQ-032 Defaults, LDA then HLT: T_State sequence 0,1,2,3,4,1,2,3,0; ctrl 8000 in HALT; holds for 10 cycles.
REQ-033 FIXED_LEN=1, TMAX=5, LDI: T3 ctrl = IO|AI, T4 = 0, T5 = 0, then T1.
REQ-034 JZ with flag_z=1, then JZ with flag_z=0: the first T3 asserts IO|J; the second T3 ctrl = 0 and returns to T1 after 3 states.
REQ-035 step_mode=1, step pulsed every 4 cycles: the state changes exactly once per pulse and ctrl is stable between pulses.
REQ-036 opcode 1010 issued, then HLT, then resume: error_LED rises at T3, stays high through HALT, clears on resume, and the next state is T1.
REQ-037 Clear_n low during ADD T4: ctrl=0 and T_State=0 without a clock edge; after release, ADD re-fetches from T1.
